// File: rtl/button_conditioner_if.sv
// Push-button bundle: raw levels in, conditioned pulses and timebase tick out.
interface button_conditioner_if;
  logic NextRaw;
  logic UpRaw;
  logic SetTimeRaw;
  logic SetAlarmRaw;
  logic Next;
  logic Up;
  logic SetTime;
  logic SetAlarm;
  logic Count;

  modport master (
    output NextRaw, UpRaw, SetTimeRaw, SetAlarmRaw,
    input  Next, Up, SetTime, SetAlarm, Count
  );

  modport slave (
    input  NextRaw, UpRaw, SetTimeRaw, SetAlarmRaw,
    output Next, Up, SetTime, SetAlarm, Count
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronize, debounce and prioritise four buttons; divide clock into a tick.
// Optional Up auto-repeat enabled by defining UP_AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int DB_CYCLES    = 4,
  parameter int TICK_DIV     = 50,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8
) (
  input  logic Clk,
  input  logic Reset,
  button_conditioner_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam int TW = $clog2(TICK_DIV);

  if (DB_CYCLES < 2 || DB_CYCLES > 255 ||
      TICK_DIV < 2 || TICK_DIV > 65535 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
    $error("button_conditioner: parameter out of range");
  end

  // channel order: 0 Next, 1 Up, 2 SetTime, 3 SetAlarm
  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    prev_q;
  logic [3:0]    cand;
  logic [3:0]    out_q, out_d;
  logic [CW-1:0] db_q [4];
  logic [CW-1:0] db_d [4];
  logic [TW-1:0] tick_q, tick_d;
  logic          wrap;
  logic          count_q;
  logic          up_cand;

  assign raw = {bus.SetAlarmRaw, bus.SetTimeRaw,
                bus.UpRaw, bus.NextRaw};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_q[i] == CW'(DB_CYCLES - 1))
          stable_d[i] = ~stable_q[i];
        else
          db_d[i] = db_q[i] + 1'b1;
      end
    end
  end

`ifdef UP_AUTO_REPEAT_EN
  logic [15:0] rpt_q, rpt_d;
  logic        first_q, first_d;
  logic        rpt_hit;

  // rpt_q counts cycles since the last Up candidate while held
  always_comb begin
    rpt_d   = rpt_q;
    first_d = first_q;
    rpt_hit = 1'b0;
    if (!stable_q[1]) begin
      rpt_d   = '0;
      first_d = 1'b0;
    end else if (!prev_q[1]) begin
      rpt_d   = 16'd1;
      first_d = 1'b1;
    end else begin
      rpt_hit = rpt_q == (first_q ? 16'(REPEAT_DELAY)
                                  : 16'(REPEAT_RATE));
      if (rpt_hit) begin
        rpt_d   = 16'd1;
        first_d = 1'b0;
      end else begin
        rpt_d = rpt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rpt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  assign up_cand = (stable_q[1] & ~prev_q[1]) | rpt_hit;
`else
  assign up_cand = stable_q[1] & ~prev_q[1];
`endif

  assign cand = {stable_q[3] & ~prev_q[3],
                 stable_q[2] & ~prev_q[2],
                 up_cand,
                 stable_q[0] & ~prev_q[0]};

  // SetTime > SetAlarm > Next > Up; losers are dropped
  always_comb begin
    out_d = '0;
    if (cand[2])      out_d[2] = 1'b1;
    else if (cand[3]) out_d[3] = 1'b1;
    else if (cand[0]) out_d[0] = 1'b1;
    else if (cand[1]) out_d[1] = 1'b1;
  end

  assign wrap   = tick_q == TW'(TICK_DIV - 1);
  assign tick_d = wrap ? '0 : tick_q + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      tick_q   <= '0;
      count_q  <= 1'b0;
      for (int i = 0; i < 4; i++) db_q[i] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      out_q    <= out_d;
      tick_q   <= tick_d;
      count_q  <= wrap;
      for (int i = 0; i < 4; i++) db_q[i] <= db_d[i];
    end
  end

  assign bus.Next     = out_q[0];
  assign bus.Up       = out_q[1];
  assign bus.SetTime  = out_q[2];
  assign bus.SetAlarm = out_q[3];
  assign bus.Count    = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed + random stimulus for button_conditioner against a windowed
// reference model of debounce, priority and timebase behaviour.
module tb_button_conditioner;
  localparam int DB = 4;
  localparam int TD = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] raw = '0;

  always #5 clk = ~clk;

  button_conditioner_if bus();

  assign bus.NextRaw     = raw[0];
  assign bus.UpRaw       = raw[1];
  assign bus.SetTimeRaw  = raw[2];
  assign bus.SetAlarmRaw = raw[3];

  button_conditioner #(
    .DB_CYCLES(DB), .TICK_DIV(TD),
    .REPEAT_DELAY(16), .REPEAT_RATE(8)
  ) dut (
    .Clk(clk), .Reset(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // model: edges counted from reset release, raw_h[ch][n] = level at edge n
  int n;
  bit raw_h [4][0:4095];
  bit stable [4];
  int last_flip [4];
  bit rise_prev [4];
  logic [4:0] last_exp;

  function automatic bit rv(int ch, int k);
    return (k >= 1) ? raw_h[ch][k] : 1'b0;
  endfunction

  task automatic model_reset();
    n = 0;
    for (int c = 0; c < 4; c++) begin
      stable[c] = 1'b0;
      last_flip[c] = 0;
      rise_prev[c] = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.Count, bus.SetAlarm, bus.SetTime, bus.Up, bus.Next};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  // one clock: apply levels, advance model, check #1 after the edge
  task automatic step(input logic [3:0] r, input string tag);
    logic [4:0] exp;
    bit all;
    raw = r;
    @(posedge clk);
    n++;
    for (int c = 0; c < 4; c++) raw_h[c][n] = r[c];
    exp = '0;
    if (rise_prev[2])      exp[2] = 1'b1;
    else if (rise_prev[3]) exp[3] = 1'b1;
    else if (rise_prev[0]) exp[0] = 1'b1;
    else if (rise_prev[1]) exp[1] = 1'b1;
    exp[4] = (n % TD) == 0;
    for (int c = 0; c < 4; c++) begin
      all = (n - DB) >= last_flip[c];
      for (int k = n - 1 - DB; k <= n - 2; k++)
        if (rv(c, k) == stable[c]) all = 1'b0;
      rise_prev[c] = all && !stable[c];
      if (all) begin
        stable[c] = ~stable[c];
        last_flip[c] = n;
      end
    end
    last_exp = exp;
    #1 check(tag, exp);
    @(negedge clk);
  endtask

  task automatic hold_reset(input int cycles, input string tag);
    rst = 1'b1;
    #1 check(tag, 5'b0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 check(tag, 5'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [3:0] cur;
  int dwell [4];

  initial begin
    model_reset();
    #12 check("reset_state", 5'b0);
    @(negedge clk);
    rst = 1'b0;

    repeat (20) step(4'b0001, "next_hold");
    repeat (8) step(4'b0000, "next_rel");

    for (int i = 0; i < 8; i++)
      step((i % 2 == 0) ? 4'b0010 : 4'b0000, "up_bounce");
    repeat (12) step(4'b0010, "up_hold");
    repeat (8) step(4'b0000, "up_rel");

    repeat (14) step(4'b0101, "st_next");
    repeat (8) step(4'b0000, "st_rel");

    repeat (14) step(4'b1111, "all_four");
    repeat (8) step(4'b0000, "all_rel");

    cur = '0;
    for (int c = 0; c < 4; c++) dwell[c] = $urandom_range(1, 10);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++) begin
        dwell[c]--;
        if (dwell[c] <= 0) begin
          cur[c] = ~cur[c];
          dwell[c] = ($urandom_range(0, 2) == 0) ?
                     $urandom_range(8, 20) : $urandom_range(1, 5);
        end
      end
      step(cur, "random");
    end
    repeat (8) step(4'b0000, "rand_rel");

    raw = 4'b1000;
    hold_reset(1, "rst_pre");
    repeat (4) step(4'b1000, "sa_debounce");
    hold_reset(3, "rst_mid");
    repeat (12) step(4'b1000, "sa_after_rst");
    repeat (8) step(4'b0000, "sa_rel");

    hold_reset(1, "rst_idle");
    repeat (150) step(4'b0000, "idle_count");
    tests++;
    assert (last_exp[4] === 1'b1 && bus.Count === 1'b1) else begin
      fails++;
      $error("FAIL count_150 observed=%b expected=1", bus.Count);
    end
    hold_reset(2, "rst_async");
    repeat (60) step(4'b0001, "held_thru_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
